// File: rtl/nand4_sweep_pkg.sv
// Shared types and constants for the 4-input gate sweep controller.
package nand4_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } state_e;

    localparam int unsigned NUM_VECTORS = 16;
    localparam int unsigned VEC_W       = 4;
    localparam int unsigned ERR_W       = 5;

    localparam logic [NUM_VECTORS-1:0] NAND4_TRUTH = 16'h7FFF;
    localparam logic [NUM_VECTORS-1:0] AND4_TRUTH  = 16'h8000;

endpackage

// File: rtl/nand4_sweep_ctrl.sv
// Drives all 16 input vectors of a 4-input gate in order, waits a settle time,
// samples the gate output and scores it against an expected truth table.
module nand4_sweep_ctrl
    import nand4_sweep_pkg::*;
#(
    parameter int unsigned                SETTLE_CYCLES = 2,
    parameter logic [NUM_VECTORS-1:0]     EXP_TRUTH     = NAND4_TRUTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             e,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [VEC_W-1:0] first_fail_vec
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VECTORS - 1);

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VEC_W-1:0]   gate_q, gate_d;
    logic               busy_d, done_d, pass_d, fail_valid_d;
    logic [ERR_W-1:0]   err_count_d;
    logic [VEC_W-1:0]   first_fail_vec_d;
    logic               in_sweep;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            vec_q          <= '0;
            cnt_q          <= '0;
            gate_q         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
        end else begin
            state_q        <= state_d;
            vec_q          <= vec_d;
            cnt_q          <= cnt_d;
            gate_q         <= gate_d;
            busy           <= busy_d;
            done           <= done_d;
            pass           <= pass_d;
            err_count      <= err_count_d;
            fail_valid     <= fail_valid_d;
            first_fail_vec <= first_fail_vec_d;
        end
    end

    // Next state; outputs are derived from the next state so they land with it
    always_comb begin
        state_d          = state_q;
        vec_d            = vec_q;
        cnt_d            = cnt_q;
        pass_d           = pass;
        err_count_d      = err_count;
        fail_valid_d     = fail_valid;
        first_fail_vec_d = first_fail_vec;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d          = DRIVE;
                    vec_d            = '0;
                    cnt_d            = '0;
                    pass_d           = 1'b0;
                    err_count_d      = '0;
                    fail_valid_d     = 1'b0;
                    first_fail_vec_d = '0;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CHECK: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (e != EXP_TRUTH[vec_q]) begin
                        err_count_d = err_count + ERR_W'(1);
                        if (!fail_valid) begin
                            fail_valid_d     = 1'b1;
                            first_fail_vec_d = vec_q;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        state_d = FINISH;
                        pass_d  = (err_count_d == '0);
                    end else begin
                        state_d = DRIVE;
                        vec_d   = vec_q + VEC_W'(1);
                        cnt_d   = '0;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_sweep = (state_d == DRIVE) || (state_d == CHECK);
        busy_d   = in_sweep;
        done_d   = (state_d == FINISH);
        gate_d   = in_sweep ? vec_d : '0;
    end

    assign a = gate_q[3];
    assign b = gate_q[2];
    assign c = gate_q[1];
    assign d = gate_q[0];

endmodule
